// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg -- shared definitions for NoC processing elements.
//
// Flit layout, MSB first:  {valid, head, dest[DEST_W], vc[VC_W], data[DATA_W]}
// Layout helpers take the block's width parameters, so every PE derives the
// same field positions from one place. Also holds the PE control FSM states.
// -----------------------------------------------------------------------------
package noc_pkg;

  // valid + head control bits at the top of every flit
  localparam int CTRL_W   = 2;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MUL     = 2'd1,
    SEND    = 2'd2
  } state_t;

  function automatic int flit_width(input int data_w, input int dest_w, input int vc_w);
    return CTRL_W + dest_w + vc_w + data_w;
  endfunction

  function automatic int valid_pos(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int head_pos(input int flit_w);
    return flit_w - 2;
  endfunction

  function automatic int vc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int dest_lsb(input int data_w, input int vc_w);
    return data_w + vc_w;
  endfunction

endpackage

// File: rtl/mul_pe_mult.sv
// -----------------------------------------------------------------------------
// mul_pe_mult -- registered DATA_W x DATA_W unsigned multiplier.
//
// The product is captured into o_result on every edge where i_en is high.
// Default build keeps the low DATA_W bits of the product. With the macro
// MUL_PE_SATURATE_EN defined, any non-zero upper product bit clamps the
// result to all ones.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, clears the result
//   i_en      in   capture the product this edge
//   i_a, i_b  in   DATA_W unsigned operands
//   o_result  out  registered DATA_W result
// -----------------------------------------------------------------------------
module mul_pe_mult #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] r_result;

`ifdef MUL_PE_SATURATE_EN
  logic [2*DATA_W-1:0] w_product;

  // Zero-extend first so the full double-width product is formed.
  assign w_product = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign w_result  = (|w_product[2*DATA_W-1:DATA_W]) ? '1 : w_product[DATA_W-1:0];
`else
  // Only the low half survives, so a DATA_W-wide multiply is exact here.
  assign w_result = i_a * i_b;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (i_en) begin
      r_result <= w_result;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/mul_pe.sv
// -----------------------------------------------------------------------------
// mul_pe -- multiplying processing element on a flit interface.
//
// Collects operand A (vc LSB = 0) and operand B (vc LSB = 1) from input flits,
// multiplies them in a registered multiplier, then sends NUM_DEST result flits,
// one per out_ready handshake, to DEST_LIST/VC_LIST entries 0..NUM_DEST-1.
// Table entry 0 is the most significant DEST_W (VC_W) slice, so a literal
// {d0, d1, d2} sends to d0 first.
//
// Optional feature: define MUL_PE_SATURATE_EN for unsigned saturation of the
// result instead of truncation (implemented in mul_pe_mult).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   input_flit1   in   operand flit {valid, head, dest, vc, data}
//   in_ready      out  an operand flit can be accepted this cycle
//   output_flit1  out  result flit (zero when not sending)
//   ready_send    out  output_flit1 is valid
//   out_ready     in   downstream accepts output_flit1 this cycle
//
// Timing: the completing operand is accepted on edge n; edge n+1 registers
// the product and enters SEND, so ready_send is high during the second cycle
// after the accepting edge.
// -----------------------------------------------------------------------------
module mul_pe
  import noc_pkg::*;
#(
  parameter int                         DATA_W    = 64,
  parameter int                         DEST_W    = 4,
  parameter int                         VC_W      = 1,
  parameter int                         NUM_DEST  = 1,
  parameter logic [NUM_DEST*DEST_W-1:0] DEST_LIST = {NUM_DEST{DEST_W'(4'b1000)}},
  parameter logic [NUM_DEST*VC_W-1:0]   VC_LIST   = '0,
  localparam int                        FLIT_W    = flit_width(DATA_W, DEST_W, VC_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] input_flit1,
  output logic              in_ready,
  output logic [FLIT_W-1:0] output_flit1,
  output logic              ready_send,
  input  logic              out_ready
);

  localparam int VALID_POS = valid_pos(FLIT_W);
  localparam int HEAD_POS  = head_pos(FLIT_W);
  localparam int VC_LSB    = vc_lsb(DATA_W);
  localparam int DEST_LSB  = dest_lsb(DATA_W, VC_W);
  // NUM_DEST is at most 4, so two bits always cover the copy index.
  localparam int IDX_W     = 2;

  state_t             r_state, w_next_state;
  logic [DATA_W-1:0]  r_op_a, r_op_b;
  logic               r_flag_a, r_flag_b;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  w_result;

  logic               w_in_valid, w_accept, w_sel_b, w_both_set, w_last, w_mul_en;
  logic [VC_W-1:0]    w_in_vc;
  logic [DATA_W-1:0]  w_in_data;
  logic [DEST_W-1:0]  w_dest;
  logic [VC_W-1:0]    w_vc;
  logic               w_unused;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  assign w_in_valid = input_flit1[VALID_POS] & input_flit1[HEAD_POS];
  assign w_in_vc    = input_flit1[VC_LSB +: VC_W];
  assign w_in_data  = input_flit1[DATA_LSB +: DATA_W];
  assign w_sel_b    = w_in_vc[0];
  // The incoming destination field carries no meaning for this PE.
  assign w_unused   = ^input_flit1[DEST_LSB +: DEST_W];

  // Decoded from state rather than in_ready to keep the comb block loop-free.
  assign w_accept   = w_in_valid && (r_state == COLLECT);
  // Both operands are present once this edge's flit is taken into account.
  assign w_both_set = (r_flag_a | ~w_sel_b) & (r_flag_b | w_sel_b);
  assign w_last     = (r_idx == IDX_W'(NUM_DEST - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    ready_send   = 1'b0;
    w_mul_en     = 1'b0;
    unique case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (w_accept && w_both_set) w_next_state = MUL;
      end
      MUL: begin
        w_mul_en     = 1'b1;
        w_next_state = SEND;
      end
      SEND: begin
        ready_send = 1'b1;
        if (out_ready && w_last) w_next_state = COLLECT;
      end
      default: w_next_state = COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand slots and copy index
  // ---------------------------------------------------------------------------
  // NOTE: operand registers are reset along with the flags so nothing stale
  // is visible after reset, even though the flags alone gate their use.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
      r_idx    <= '0;
    end else begin
      if (w_accept && !w_sel_b) r_op_a <= w_in_data;
      if (w_accept &&  w_sel_b) r_op_b <= w_in_data;

      if (w_accept && w_both_set) begin
        r_flag_a <= 1'b0;
        r_flag_b <= 1'b0;
      end else if (w_accept) begin
        r_flag_a <= r_flag_a | ~w_sel_b;
        r_flag_b <= r_flag_b |  w_sel_b;
      end

      if (r_state == MUL) begin
        r_idx <= '0;
      end else if (r_state == SEND && out_ready) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  mul_pe_mult #(.DATA_W(DATA_W)) u_mult (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_mul_en),
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .o_result (w_result)
  );

  // ---------------------------------------------------------------------------
  // Output flit
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dest = '0;
    w_vc   = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_dest = DEST_LIST[(NUM_DEST-1-i)*DEST_W +: DEST_W];
        w_vc   = VC_LIST[(NUM_DEST-1-i)*VC_W +: VC_W];
      end
    end
  end

  assign output_flit1 = ready_send ? {2'b11, w_dest, w_vc, w_result} : '0;

endmodule

// File: tb/tb_mul_pe.sv
// -----------------------------------------------------------------------------
// tb_mul_pe -- self-checking bench for mul_pe.
//
// u_dut  : default parameters (one copy to dest 4'b1000).
// u_dut3 : NUM_DEST = 3, DEST_LIST = {2, 5, 8}.
// Stimulus pushes expected result flits into a queue per DUT; a monitor per
// DUT compares each presented flit against the queue head on the falling
// edge and pops it when the handshake will complete.
// -----------------------------------------------------------------------------
module tb_mul_pe;

  localparam int DW = 64;
  localparam int FW = 71;

`ifdef MUL_PE_SATURATE_EN
  localparam logic [DW-1:0] BIG_EXP = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [DW-1:0] BIG_EXP = 64'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] flit_in, flit_out, flit_in3, flit_out3;
  logic          in_ready, ready_send, out_ready;
  logic          in_ready3, ready_send3, out_ready3;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_q3[$];

  // 0 = out_ready low, 1 = high, 2 = random
  int or_mode = 0;

  // reference model of the operand slots of u_dut
  logic [DW-1:0] m_a, m_b;
  bit            m_has_a = 0, m_has_b = 0;

  always #5 clk = ~clk;

  mul_pe u_dut (
    .clk          (clk),
    .rst          (rst),
    .input_flit1  (flit_in),
    .in_ready     (in_ready),
    .output_flit1 (flit_out),
    .ready_send   (ready_send),
    .out_ready    (out_ready)
  );

  mul_pe #(
    .NUM_DEST  (3),
    .DEST_LIST ({4'd2, 4'd5, 4'd8}),
    .VC_LIST   (3'b000)
  ) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .input_flit1  (flit_in3),
    .in_ready     (in_ready3),
    .output_flit1 (flit_out3),
    .ready_send   (ready_send3),
    .out_ready    (out_ready3)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] ref_product(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`ifdef MUL_PE_SATURATE_EN
    if (p > {{DW{1'b0}}, {DW{1'b1}}}) return '1;
`endif
    return p[DW-1:0];
  endfunction

  function automatic logic [FW-1:0] mk_in(input bit sel_b, input logic [DW-1:0] d);
    return {2'b11, 4'h0, sel_b, d};
  endfunction

  function automatic logic [FW-1:0] mk_out(input logic [3:0] dest, input logic [DW-1:0] r);
    return {2'b11, dest, 1'b0, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && ready_send) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=%0h required=no_output", flit_out);
      end else begin
        check("out_flit", flit_out, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ready_send3) begin
      if (exp_q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out3_unexpected actual=%0h required=no_output", flit_out3);
      end else begin
        check("out3_flit", flit_out3, exp_q3[0]);
        if (out_ready3) void'(exp_q3.pop_front());
      end
    end
  end

  // out_ready driver for u_dut
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_op(input bit sel_b, input logic [DW-1:0] d);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    flit_in = mk_in(sel_b, d);
    @(posedge clk); #1;
    flit_in = '0;
    if (sel_b) begin m_b = d; m_has_b = 1; end
    else       begin m_a = d; m_has_a = 1; end
    if (m_has_a && m_has_b) begin
      exp_q.push_back(mk_out(4'b1000, ref_product(m_a, m_b)));
      m_has_a = 0;
      m_has_b = 0;
    end
  endtask

  task automatic send_op3(input bit sel_b, input logic [DW-1:0] d);
    int guard = 0;
    while (!in_ready3 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready3) begin
      check("in_ready3_timeout", in_ready3, 1);
      return;
    end
    flit_in3 = mk_in(sel_b, d);
    @(posedge clk); #1;
    flit_in3 = '0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((ready_send || exp_q.size() != 0) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) check("idle_timeout", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int guard;
    logic [DW-1:0] d;

    rst        = 1'b1;
    flit_in    = '0;
    flit_in3   = '0;
    out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",   in_ready,   1);
    check("rst_ready_send", ready_send, 0);
    check("rst_flit",       flit_out,   0);

    // A = 3, B = 5 with out_ready high: latency and single copy
    or_mode = 1;
    @(posedge clk); #1;
    send_op(0, 64'd3);
    send_op(1, 64'd5);
    @(negedge clk);
    check("lat1_ready_send", ready_send, 0);
    check("mul_in_ready",    in_ready,   0);
    @(negedge clk);
    check("lat2_ready_send", ready_send, 1);
    check("basic_flit", flit_out, {2'b11, 4'b1000, 1'b0, 64'd15});
    @(negedge clk);
    check("one_copy",     ready_send, 0);
    check("back_collect", in_ready,   1);
    @(posedge clk); #1;

    // overwrite of A, and a flit offered while busy is ignored
    or_mode = 0;
    @(posedge clk); #1;
    send_op(0, 64'd7);
    send_op(0, 64'd9);
    send_op(1, 64'd2);
    flit_in = mk_in(0, 64'd100);
    @(negedge clk);
    check("busy_mul_in_ready", in_ready, 0);
    @(negedge clk);
    check("busy_send_in_ready", in_ready,   0);
    check("held_ready_send",    ready_send, 1);
    check("overwrite_result",   flit_out[DW-1:0], 64'd18);
    @(posedge clk); #1;
    flit_in = '0;
    or_mode = 1;
    wait_idle();
    send_op(1, 64'd4);
    send_op(0, 64'd6);
    wait_idle();

    // randomized operands, random back-pressure
    or_mode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 64'($urandom_range(0, 1000));
        1:       d = {$urandom, $urandom};
        2:       d = 64'd1 << $urandom_range(20, 63);
        default: d = {32'h0, $urandom};
      endcase
      send_op(1'($urandom_range(0, 1)), d);
    end
    or_mode = 1;
    wait_idle();

    // 2^63 * 2^63: truncates to 0 or saturates
    send_op(0, 64'h8000_0000_0000_0000);
    send_op(1, 64'h8000_0000_0000_0000);
    @(negedge clk);
    @(negedge clk);
    check("big_ready_send", ready_send, 1);
    check("big_result", flit_out[DW-1:0], BIG_EXP);
    @(posedge clk); #1;
    wait_idle();

    // reset while a result is waiting on back-pressure
    or_mode = 0;
    @(posedge clk); #1;
    send_op(0, 64'd11);
    send_op(1, 64'd13);
    guard = 0;
    while (!ready_send && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("pre_rst_ready_send", ready_send, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_has_a = 0;
    m_has_b = 0;
    check("mid_rst_ready_send", ready_send, 0);
    check("mid_rst_flit",       flit_out,   0);
    check("mid_rst_in_ready",   in_ready,   1);
    or_mode = 1;
    @(posedge clk); #1;
    send_op(0, 64'd12);
    send_op(1, 64'd12);
    wait_idle();

    // three copies with back-pressure on u_dut3
    send_op3(0, 64'd6);
    send_op3(1, 64'd7);
    exp_q3.push_back(mk_out(4'd2, 64'd42));
    exp_q3.push_back(mk_out(4'd5, 64'd42));
    exp_q3.push_back(mk_out(4'd8, 64'd42));
    guard = 0;
    while (!ready_send3 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("multi_ready_send", ready_send3, 1);
    repeat (4) @(posedge clk);
    #1 out_ready3 = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_send3) n++;
    end
    check("multi_copies",    n,             3);
    check("multi_collect",   in_ready3,     1);
    check("multi_drained",   exp_q3.size(), 0);
    @(posedge clk); #1;
    out_ready3 = 1'b0;

    check("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_pe.md
MUL_PE -- requirements
Module: mul_pe

Interface
REQ-001 Parameter DATA_W, default 64: operand and result payload width.
REQ-002 Parameter DEST_W, default 4: destination field width.
REQ-003 Parameter VC_W, default 1: virtual-channel field width.
REQ-004 Parameter NUM_DEST, default 1, range 1..4: result copies sent per product.
REQ-005 Parameter DEST_LIST, default all 4'b1000: packed NUM_DEST x DEST_W destination table, entry 0 sent first.
REQ-006 Parameter VC_LIST, default all 0: packed NUM_DEST x VC_W VC table, indexed with DEST_LIST.
REQ-007 Derived FLIT_W = 2 + DEST_W + VC_W + DATA_W (71 at defaults).
REQ-008 Port: clk  in  1  clock, all logic on rising edge.
REQ-009 Port: rst  in  1  one clock; reset is synchronous and active-high.
REQ-010 Port: input_flit1  in  FLIT_W  flit {valid, head, dest, vc, data}, MSB first.
REQ-011 Port: in_ready  out  1  high when an operand flit can be accepted this cycle.
REQ-012 Port: output_flit1  out  FLIT_W  result flit.
REQ-013 Port: ready_send  out  1  output_flit1 valid.
REQ-014 Port: out_ready  in  1  downstream accepts output_flit1 this cycle.

Function
REQ-015 Input flit is valid when bits FLIT_W-1 and FLIT_W-2 are both 1; accepted only when valid and in_ready are high on the same edge.
REQ-016 The LSB of the accepted flit's vc field selects the slot: 0 = operand A, 1 = operand B; the data field is stored and that slot's flag is set.
REQ-017 A second flit for an already-filled slot overwrites it; the latest value is used.
REQ-018 FSM states: COLLECT, MUL, SEND; in_ready = 1 only in COLLECT.
REQ-019 COLLECT -> MUL on the edge where both flags become set; both flags clear on that edge.
REQ-020 MUL: the full 2*DATA_W unsigned product is formed and the DATA_W result registered; MUL -> SEND on the next edge, copy index cleared to 0.
REQ-021 Latency: ready_send rises exactly 2 cycles after the edge accepting the completing operand.
REQ-022 SEND: output_flit1 = {1, 1, DEST_LIST[idx], VC_LIST[idx], result}; ready_send held high and output_flit1 held stable until out_ready is high.
REQ-023 Each edge with ready_send and out_ready both high increments idx; after the NUM_DEST-th handshake, SEND -> COLLECT and ready_send drops on that edge.
REQ-024 out_ready high outside SEND has no effect; out_ready held high gives one copy per cycle.
REQ-025 Default result is the low DATA_W bits of the product (truncation).

Reset
REQ-026 rst high on any edge, including mid-SEND or mid-MUL: state = COLLECT, flags = 0, idx = 0, ready_send = 0, output_flit1 = 0, result = 0; in_ready = 1 from the first cycle after reset.
REQ-027 Reset has priority over every flit and handshake in the same cycle.

Configuration
REQ-028 Macro MUL_PE_SATURATE_EN defined: if the upper DATA_W product bits are non-zero, result = all ones (unsigned saturation).
REQ-029 Macro MUL_PE_SATURATE_EN undefined: truncation per REQ-025; no other behaviour changes.

Structure
REQ-030 Shared package noc_pkg holds the flit field offsets/widths, the valid/head bit positions and the FSM state enum (COLLECT, MUL, SEND).
REQ-031 One sub-module, mul_pe_mult: registered DATA_W x DATA_W unsigned multiplier with truncate/saturate output, used in the MUL state.

Verification
REQ-032 Defaults: A = 3 (vc 0), then B = 5 (vc 1), out_ready = 1 -> ready_send exactly 2 cycles after B, output_flit1 = {1, 1, 4'b1000, 0, 64'd15}, one cycle only.
REQ-033 A = 7, A = 9, B = 2 -> result 18 (overwrite); in_ready = 0 during MUL/SEND, and a valid flit offered then is ignored.
REQ-034 NUM_DEST = 3, DEST_LIST = {2, 5, 8}, out_ready low 4 cycles then high -> flit held stable, then copies to 2, 5, 8 on consecutive cycles; COLLECT follows.
REQ-035 A = B = 2^63 -> 0 without MUL_PE_SATURATE_EN, 64'hFFFF_FFFF_FFFF_FFFF with it.
REQ-036 rst pulsed while ready_send = 1 and out_ready = 0 -> next cycle ready_send = 0, output_flit1 = 0, in_ready = 1; a new A/B pair then produces a correct product.
